store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffered store entries (power of two, 2..8).
REQ-002 Parameter MEM_LAT, default 4, cycles a memory write is held before retirement (1..15).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_b  input  1  reset, asynchronous, active-high (1 = reset asserted); name kept per codebase.
REQ-005 st_valid  input  1  store request from the cache.
REQ-006 st_addr  input  32  store byte address; bits [1:0] ignored, compare on [31:2].
REQ-007 st_data  input  4x8  store word, byte array [0:3], byte 0 most significant.
REQ-008 st_ready  output  1  buffer can accept a store this cycle.
REQ-009 rd_addr  input  32  cache read/lookup address.
REQ-010 rd_hit  output  1  rd_addr matches a buffered entry.
REQ-011 rd_data  output  4x8  forwarded data of the newest matching entry; all zero when rd_hit=0.
REQ-012 rd_grant  output  1  memory port free for cache reads this cycle.
REQ-013 mem_addr  output  32  memory address.
REQ-014 mem_data_in  output  4x8  memory write data.
REQ-015 mem_write_en  output  1  memory write strobe.
REQ-016 empty  output  1  no entries held and no write in progress (used for halt drain).

Function
REQ-017 Circular FIFO; head/tail pointers of log2(DEPTH)+1 bits; count = tail - head modulo 2*DEPTH.
REQ-018 st_ready SHALL be 1 iff registered count < DEPTH; a pop in the same cycle does not raise st_ready.
REQ-019 Accepted store (st_valid & st_ready) writes {st_addr[31:2], st_data} at tail; tail increments, wrapping.
REQ-020 Coalescing: if st_addr[31:2] equals the youngest entry and that entry is not the one being written to memory, its data is overwritten and tail does not move; a coalesced store needs no free slot.
REQ-021 Drain FSM states IDLE and WRITE; reset state IDLE.
REQ-022 IDLE -> WRITE when count > 0; the latency counter loads MEM_LAT-1.
REQ-023 In WRITE: mem_write_en=1, mem_addr={head addr,2'b00}, mem_data_in=head data, held stable; counter decrements each cycle.
REQ-024 When the counter reaches 0, head is popped; if count after the pop is > 0, the counter reloads and the FSM stays in WRITE, otherwise it goes to IDLE.
REQ-025 In IDLE: mem_write_en=0, mem_addr=rd_addr, mem_data_in=0, rd_grant=1; in WRITE rd_grant=0.
REQ-026 Forwarding is combinational over all valid entries, including the head during WRITE; the newest match wins.
REQ-027 A store and a lookup to the same word in the same cycle: rd_data reflects pre-edge contents; the new data is visible the next cycle.
REQ-028 empty = (count == 0) & (state == IDLE).

Reset
REQ-029 Asserting rst_b SHALL immediately clear head, tail, counter and valid bits and force IDLE, independent of clk.
REQ-030 During reset: st_ready=1, rd_hit=0, rd_data=0, mem_write_en=0, mem_data_in=0, rd_grant=1, empty=1, mem_addr=rd_addr.
REQ-031 Reset during WRITE abandons the write; the entry is lost and not retried.

Structure
REQ-032 Package store_buffer_pkg holds the state enum, the entry struct {addr[29:0], data 4x8}, and DEPTH/MEM_LAT defaults.
REQ-033 One sub-module, sb_match: a combinational DEPTH-way address compare with newest-first priority, producing hit and data.
REQ-034 Target size is 120-400 lines of RTL.

Verification
REQ-035 Reset, then one store at addr 0x100, data {DE,AD,BE,EF}: mem_write_en high for exactly 4 cycles with mem_addr=0x100, then empty=1.
REQ-036 Five back-to-back stores to 0x0,0x4,0x8,0xC,0x10: st_ready falls after the fourth; the fifth is accepted only after the first retires; memory sees the writes in order.
REQ-037 Store 0x200={11,22,33,44}, then store 0x200={55,66,77,88} next cycle while 0x200 is not draining: one memory write of {55,66,77,88}.
REQ-038 Stores to 0x40={01,..} then 0x40 queued behind another entry, then rd_addr=0x40: rd_hit=1 with the newer data; rd_addr=0x44 gives rd_hit=0, rd_data=0.
REQ-039 Assert rst_b on the 2nd cycle of WRITE: mem_write_en drops in the same cycle, empty=1, and no further writes occur.

Source files
------------

// File: rtl/store_buffer_pkg.sv
// Shared types and defaults for the store buffer: drain FSM states and
// the buffered entry layout (word address plus four data bytes).
package store_buffer_pkg;

    localparam int DEPTH_DEF   = 4;
    localparam int MEM_LAT_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    // Byte 0 is the most significant byte of the packed word.
    typedef logic [0:3][7:0] word_t;

    typedef struct packed {
        logic [29:0] addr;
        word_t       data;
    } entry_t;

endpackage

// File: rtl/store_buffer_match.sv
// sb_match: combinational DEPTH-way word-address compare over the valid
// entries; the entry closest to the tail (newest) wins.
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  entry_t                       entries [DEPTH],
    input  logic   [DEPTH-1:0]           valid,
    input  logic   [$clog2(DEPTH)-1:0]   newest,
    input  logic   [29:0]                addr,
    output logic                         hit,
    output word_t                        data
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] idx;

    // Walk oldest to newest so a later (younger) match overrides an older one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            idx = newest - AW'(k);
            if (valid[idx] && entries[idx].addr == addr) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: circular FIFO of word stores with youngest-entry coalescing,
// read forwarding, and a drain FSM that holds each memory write MEM_LAT cycles.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int MEM_LAT = MEM_LAT_DEF
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        st_valid,
    input  logic [31:0] st_addr,
    input  word_t       st_data,
    output logic        st_ready,
    input  logic [31:0] rd_addr,
    output logic        rd_hit,
    output word_t       rd_data,
    output logic        rd_grant,
    output logic [31:0] mem_addr,
    output word_t       mem_data_in,
    output logic        mem_write_en,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t           state, state_nx;
    logic [PW-1:0]    head, tail, count, count_nx;
    logic [3:0]       lat, lat_nx;
    logic [DEPTH-1:0] valid, valid_nx;
    entry_t           entries [DEPTH];
    entry_t           head_entry;
    logic [AW-1:0]    head_idx, tail_idx, newest_idx;
    logic             youngest_match, coalesce, push, pop;
    logic             unused_low;

    assign unused_low = ^st_addr[1:0];

    assign head_idx   = head[AW-1:0];
    assign tail_idx   = tail[AW-1:0];
    assign newest_idx = tail_idx - AW'(1);
    assign count      = tail - head;
    assign head_entry = entries[head_idx];

    assign st_ready = (count < PW'(DEPTH));

    // The head entry is frozen once its write starts, so it is never a coalesce target.
    assign youngest_match = (count != '0) && (entries[newest_idx].addr == st_addr[31:2]);
    assign coalesce = st_valid && youngest_match && !(state == WRITE && count == PW'(1));
    assign push     = st_valid && st_ready && !coalesce;
    assign pop      = (state == WRITE) && (lat == 4'd0);
    assign count_nx = count - PW'(pop) + PW'(push);

    always_comb begin
        valid_nx = valid;
        if (pop)  valid_nx[head_idx] = 1'b0;
        if (push) valid_nx[tail_idx] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        lat_nx   = lat;
        case (state)
            IDLE: begin
                if (count != '0) begin
                    state_nx = WRITE;
                    lat_nx   = LAT_LOAD;
                end
            end
            WRITE: begin
                if (lat == 4'd0) begin
                    lat_nx = LAT_LOAD;
                    if (count_nx == '0) state_nx = IDLE;
                end else begin
                    lat_nx = lat - 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_b) begin
        if (rst_b) begin
            state <= IDLE;
            head  <= '0;
            tail  <= '0;
            lat   <= '0;
            valid <= '0;
        end else begin
            state <= state_nx;
            lat   <= lat_nx;
            valid <= valid_nx;
            if (pop)  head <= head + PW'(1);
            if (push) tail <= tail + PW'(1);
        end
    end

    // Entry payload is qualified by valid, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail_idx] <= '{addr: st_addr[31:2], data: st_data};
        end else if (coalesce) begin
            entries[newest_idx].data <= st_data;
        end
    end

    sb_match #(.DEPTH(DEPTH)) u_match (
        .entries (entries),
        .valid   (valid),
        .newest  (newest_idx),
        .addr    (rd_addr[31:2]),
        .hit     (rd_hit),
        .data    (rd_data)
    );

    assign mem_write_en = (state == WRITE);
    assign rd_grant     = (state == IDLE);
    assign mem_addr     = (state == WRITE) ? {head_entry.addr, 2'b00} : rd_addr;
    assign mem_data_in  = (state == WRITE) ? head_entry.data : '0;
    assign empty        = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed table, corner-case sequences and random
// traffic checked against a queue-based reference model.
module tb_store_buffer;

    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 4;

    logic             clk = 1'b0;
    logic             rst_b;
    logic             st_valid;
    logic [31:0]      st_addr;
    logic [0:3][7:0]  st_data;
    logic             st_ready;
    logic [31:0]      rd_addr;
    logic             rd_hit;
    logic [0:3][7:0]  rd_data;
    logic             rd_grant;
    logic [31:0]      mem_addr;
    logic [0:3][7:0]  mem_data_in;
    logic             mem_write_en;
    logic             empty;

    store_buffer #(.DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .st_valid     (st_valid),
        .st_addr      (st_addr),
        .st_data      (st_data),
        .st_ready     (st_ready),
        .rd_addr      (rd_addr),
        .rd_hit       (rd_hit),
        .rd_data      (rd_data),
        .rd_grant     (rd_grant),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_write_en (mem_write_en),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } ment_t;

    typedef struct {
        bit          v;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] ra;
        bit          ready;
        bit          hit;
        logic [31:0] rdd;
        bit          we;
        logic [31:0] maddr;
        bit          emp;
    } vec_t;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending stores in age order plus a write timer.
    ment_t q[$];
    bit    m_wr;
    int    m_tmr;
    ment_t m_log[$];
    ment_t o_log[$];
    int    o_run;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        q.delete();
        m_wr  = 1'b0;
        m_tmr = 0;
        o_run = 0;
    endtask

    function automatic void m_look(input logic [31:0] ra, output bit h, output logic [31:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].a == ra[31:2]) begin
                h = 1'b1;
                d = q[i].d;
                break;
            end
        end
    endfunction

    // Drive inputs just after an edge, then compare against the model mid-cycle.
    task automatic drive_check(input bit v, input logic [31:0] a, input logic [31:0] d,
                               input logic [31:0] ra);
        bit          h;
        logic [31:0] fd;
        ment_t       hd;
        ment_t       ob;
        st_valid = v;
        st_addr  = a;
        st_data  = d;
        rd_addr  = ra;
        #3;
        m_look(ra, h, fd);
        hd = '{30'd0, 32'd0};
        if (q.size() > 0) hd = q[0];
        chk("st_ready", 64'(st_ready), 64'(q.size() < DEPTH));
        chk("rd_hit", 64'(rd_hit), 64'(h));
        chk("rd_data", 64'(rd_data), 64'(fd));
        chk("mem_write_en", 64'(mem_write_en), 64'(m_wr));
        chk("rd_grant", 64'(rd_grant), 64'(!m_wr));
        chk("mem_addr", 64'(mem_addr), m_wr ? 64'({hd.a, 2'b00}) : 64'(ra));
        chk("mem_data_in", 64'(mem_data_in), m_wr ? 64'(hd.d) : 64'd0);
        chk("empty", 64'(empty), 64'(q.size() == 0 && !m_wr));
        if (mem_write_en) begin
            if (o_run == 0) begin
                ob.a = mem_addr[31:2];
                ob.d = mem_data_in;
                o_log.push_back(ob);
            end
            o_run = (o_run + 1) % MEM_LAT;
        end else begin
            o_run = 0;
        end
    endtask

    task automatic advance();
        bit    co;
        bit    pop;
        int    n0;
        ment_t t;
        @(posedge clk);
        n0  = q.size();
        co  = st_valid && n0 > 0 && q[n0-1].a == st_addr[31:2] && !(m_wr && n0 == 1);
        pop = m_wr && m_tmr == 0;
        if (co) begin
            t   = q[n0-1];
            t.d = st_data;
            q[n0-1] = t;
        end
        if (pop) m_log.push_back(q.pop_front());
        if (st_valid && !co && n0 < DEPTH) begin
            t.a = st_addr[31:2];
            t.d = st_data;
            q.push_back(t);
        end
        if (!m_wr) begin
            if (n0 > 0) begin
                m_wr  = 1'b1;
                m_tmr = MEM_LAT - 1;
            end
        end else if (pop) begin
            m_wr  = (q.size() > 0);
            m_tmr = MEM_LAT - 1;
        end else begin
            m_tmr--;
        end
        #1;
    endtask

    task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ra);
        drive_check(v, a, d, ra);
        advance();
    endtask

    task automatic drain();
        int i;
        for (i = 0; i < 200; i++) begin
            if (q.size() == 0 && !m_wr) break;
            step(1'b0, 32'h0, 32'h0, 32'h0);
        end
        chk("drain_done", 64'(i < 200), 64'd1);
        step(1'b0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic clear_logs();
        m_log.delete();
        o_log.delete();
    endtask

    vec_t tbl[8];

    initial begin
        int c;
        logic [31:0] wa [5];
        logic [31:0] wd [5];

        tbl[0] = '{1'b1, 32'h100, 32'hDEADBEEF, 32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100, 1'b1};
        tbl[1] = '{1'b0, 32'h0,   32'h0,        32'h100, 1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 32'h100, 1'b0};
        tbl[2] = '{1'b0, 32'h0,   32'h0,        32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0};
        tbl[3] = '{1'b0, 32'h0,   32'h0,        32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0};
        tbl[4] = '{1'b0, 32'h0,   32'h0,        32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0};
        tbl[5] = '{1'b0, 32'h0,   32'h0,        32'h104, 1'b1, 1'b0, 32'h0,        1'b1, 32'h100, 1'b0};
        tbl[6] = '{1'b0, 32'h0,   32'h0,        32'h104, 1'b1, 1'b0, 32'h0,        1'b0, 32'h104, 1'b1};
        tbl[7] = '{1'b0, 32'h0,   32'h0,        32'h100, 1'b1, 1'b0, 32'h0,        1'b0, 32'h100, 1'b1};

        rst_b    = 1'b1;
        st_valid = 1'b0;
        st_addr  = '0;
        st_data  = '0;
        rd_addr  = 32'h1234;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_rd_hit", 64'(rd_hit), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_mem_we", 64'(mem_write_en), 64'd0);
        chk("rst_mem_data", 64'(mem_data_in), 64'd0);
        chk("rst_rd_grant", 64'(rd_grant), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_mem_addr", 64'(mem_addr), 64'h1234);
        rst_b = 1'b0;

        // Single store: four write cycles, then empty.
        for (int i = 0; i < 8; i++) begin
            drive_check(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].ra);
            chk("tbl_st_ready", 64'(st_ready), 64'(tbl[i].ready));
            chk("tbl_rd_hit", 64'(rd_hit), 64'(tbl[i].hit));
            chk("tbl_rd_data", 64'(rd_data), 64'(tbl[i].rdd));
            chk("tbl_mem_we", 64'(mem_write_en), 64'(tbl[i].we));
            chk("tbl_mem_addr", 64'(mem_addr), 64'(tbl[i].maddr));
            chk("tbl_empty", 64'(empty), 64'(tbl[i].emp));
            advance();
        end

        // Five back-to-back stores against a four-entry buffer.
        clear_logs();
        for (int k = 0; k < 5; k++) begin
            wa[k] = 32'(k * 4);
            wd[k] = 32'hA0B0C0D0 + 32'(k);
        end
        for (int k = 0; k < 4; k++) step(1'b1, wa[k], wd[k], 32'h0);
        c = 4;
        drive_check(1'b1, wa[4], wd[4], 32'h0);
        chk("ready_after_four", 64'(st_ready), 64'd0);
        while (!st_ready && c < 20) begin
            advance();
            c++;
            drive_check(1'b1, wa[4], wd[4], 32'h0);
        end
        chk("fifth_accept_cycle", 64'(c), 64'd6);
        advance();
        drain();
        chk("b2b_write_count", 64'(o_log.size()), 64'd5);
        for (int k = 0; k < 5; k++) begin
            if (k < o_log.size()) begin
                chk("b2b_order_addr", 64'({o_log[k].a, 2'b00}), 64'(wa[k]));
                chk("b2b_order_data", 64'(o_log[k].d), 64'(wd[k]));
            end
        end

        // Coalescing into the youngest entry before its write starts.
        clear_logs();
        step(1'b1, 32'h200, 32'h11223344, 32'h0);
        step(1'b1, 32'h200, 32'h55667788, 32'h0);
        drain();
        chk("coal_write_count", 64'(o_log.size()), 64'd1);
        if (o_log.size() > 0) begin
            chk("coal_addr", 64'({o_log[0].a, 2'b00}), 64'h200);
            chk("coal_data", 64'(o_log[0].d), 64'h55667788);
        end

        // Forwarding: newest of two matching entries, plus same-cycle store/lookup.
        step(1'b1, 32'h40, 32'h01020304, 32'h0);
        step(1'b1, 32'h80, 32'hCAFEF00D, 32'h0);
        drive_check(1'b1, 32'h40, 32'hA1A2A3A4, 32'h40);
        chk("fwd_same_cycle_old", 64'(rd_data), 64'h01020304);
        advance();
        drive_check(1'b0, 32'h0, 32'h0, 32'h40);
        chk("fwd_newest_hit", 64'(rd_hit), 64'd1);
        chk("fwd_newest_data", 64'(rd_data), 64'hA1A2A3A4);
        advance();
        drive_check(1'b0, 32'h0, 32'h0, 32'h44);
        chk("fwd_miss_hit", 64'(rd_hit), 64'd0);
        chk("fwd_miss_data", 64'(rd_data), 64'd0);
        advance();
        drain();

        // Reset in the second cycle of a write abandons it.
        step(1'b1, 32'h300, 32'h0BADF00D, 32'h300);
        step(1'b0, 32'h0, 32'h0, 32'h300);
        step(1'b0, 32'h0, 32'h0, 32'h300);
        rst_b = 1'b1;
        #1;
        chk("rstw_mem_we", 64'(mem_write_en), 64'd0);
        chk("rstw_empty", 64'(empty), 64'd1);
        chk("rstw_rd_hit", 64'(rd_hit), 64'd0);
        chk("rstw_mem_addr", 64'(mem_addr), 64'h300);
        m_reset();
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        clear_logs();
        for (int k = 0; k < 10; k++) step(1'b0, 32'h0, 32'h0, 32'h300);
        chk("rstw_no_writes", 64'(o_log.size()), 64'd0);

        // Random traffic over a small address pool to exercise hits and coalescing.
        clear_logs();
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) < 55,
                 32'(($urandom_range(0, 5) << 2) | $urandom_range(0, 3)),
                 $urandom(),
                 32'(($urandom_range(0, 6) << 2) | $urandom_range(0, 3)));
        end
        drain();
        chk("rand_write_count", 64'(o_log.size()), 64'(m_log.size()));
        for (int k = 0; k < m_log.size(); k++) begin
            if (k < o_log.size()) begin
                chk("rand_write_addr", 64'(o_log[k].a), 64'(m_log[k].a));
                chk("rand_write_data", 64'(o_log[k].d), 64'(m_log[k].d));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
